// File: rtl/prbs_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : prbs_gen_multi
// Description : Run-time selectable PRBS7/9/15/23/31 word generator with
//               programmable seed and word count, valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_gen_multi #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [30:0]   seed,
  input  logic [CW-1:0] n,
  input  logic          stop,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [30:0] c_ONES = 31'h7FFF_FFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_mode, w_mode_nxt;
  logic [30:0]     r_lfsr, w_lfsr_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_valid, w_valid_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_cfg_err, w_cfg_err_nxt;

  logic [2:0]      w_gen_mode;
  logic [30:0]     w_seed_low;
  logic [30:0]     w_seed_eff;
  logic [30:0]     w_gen_s;
  logic            w_gen_fb;
  logic [DW-1:0]   w_word;
  logic            w_mode_ok;
  logic            w_handshake;

  function automatic logic [30:0] len_mask(input logic [2:0] m);
    case (m)
      3'd1:    len_mask = 31'h0000_01FF;
      3'd2:    len_mask = 31'h0000_7FFF;
      3'd3:    len_mask = 31'h007F_FFFF;
      3'd4:    len_mask = 31'h7FFF_FFFF;
      default: len_mask = 31'h0000_007F;
    endcase
  endfunction

  function automatic logic tap_fb(input logic [30:0] s, input logic [2:0] m);
    case (m)
      3'd1:    tap_fb = s[8]  ^ s[4];
      3'd2:    tap_fb = s[14] ^ s[13];
      3'd3:    tap_fb = s[22] ^ s[17];
      3'd4:    tap_fb = s[30] ^ s[27];
      default: tap_fb = s[6]  ^ s[5];
    endcase
  endfunction

  // In IDLE the word is built from the incoming seed so the first word is
  // ready one cycle after start; in RUN it continues from the held LFSR.
  always_comb begin
    w_gen_mode = (r_state == ST_IDLE) ? mode : r_mode;
    w_seed_low = seed & len_mask(mode);
    w_seed_eff = (w_seed_low == 31'd0) ? len_mask(mode) : w_seed_low;
    w_gen_s    = (r_state == ST_IDLE) ? w_seed_eff : r_lfsr;
    w_gen_fb   = 1'b0;
    w_word     = '0;
    for (int i = 0; i < DW; i++) begin
      w_gen_fb  = tap_fb(w_gen_s, w_gen_mode);
      w_word[i] = w_gen_fb;
      w_gen_s   = {w_gen_s[29:0], w_gen_fb} & len_mask(w_gen_mode);
    end
  end

  assign w_mode_ok   = (mode <= 3'd4);
  assign w_handshake = r_valid & out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_lfsr_nxt    = r_lfsr;
    w_count_nxt   = r_count;
    w_valid_nxt   = r_valid;
    w_data_nxt    = r_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cfg_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_mode_ok) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = mode;
            w_count_nxt = n;
            w_data_nxt  = w_word;
            w_lfsr_nxt  = w_gen_s;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stop wins over a same-cycle handshake; that word is dropped.
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
        end else if (w_handshake) begin
          if (r_count == CW'(1)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_data_nxt = w_word;
            w_lfsr_nxt = w_gen_s;
            if (r_count != '0) begin
              w_count_nxt = r_count - CW'(1);
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_mode    <= 3'd0;
      r_lfsr    <= c_ONES;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_count   <= w_count_nxt;
      r_valid   <= w_valid_nxt;
      r_data    <= w_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_gen_multi
// Description : Self-checking bench for prbs_gen_multi against a bit-level
//               recurrence model of the selected PRBS polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_gen_multi;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int PER15 = 32767;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [30:0]   seed = 31'd0;
  logic [CW-1:0] n = '0;
  logic          stop = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] first_word;
  logic [DW-1:0] cold_word;

  // Model: b[t] = b[t-a] ^ b[t-b]; the seed supplies b[-1..-a] (seed[0] newest).
  bit m_hist[$];
  int m_a, m_b;
  bit per_bits[PER15];

  prbs_gen_multi #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .seed(seed), .n(n),
    .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_load(input logic [2:0] m, input logic [30:0] sd);
    logic [30:0] msk;
    logic [30:0] sl;
    case (m)
      3'd1:    begin m_a = 9;  m_b = 5;  end
      3'd2:    begin m_a = 15; m_b = 14; end
      3'd3:    begin m_a = 23; m_b = 18; end
      3'd4:    begin m_a = 31; m_b = 28; end
      default: begin m_a = 7;  m_b = 6;  end
    endcase
    msk = 31'h7FFF_FFFF >> (31 - m_a);
    sl  = sd & msk;
    if (sl == 31'd0) sl = msk;
    m_hist.delete();
    for (int j = m_a - 1; j >= 0; j--) m_hist.push_back(sl[j]);
  endtask

  task automatic model_word(output logic [DW-1:0] w);
    bit b;
    for (int i = 0; i < DW; i++) begin
      b = m_hist[m_hist.size() - m_a] ^ m_hist[m_hist.size() - m_b];
      m_hist.push_back(b);
      if (m_hist.size() > 31) void'(m_hist.pop_front());
      w[i] = b;
    end
  endtask

  // Issues one counted run and follows it to the done cycle (left there).
  task automatic run_counted(input logic [2:0] m, input logic [30:0] sd,
                             input int nn, input int rpct, input bit hold_start);
    logic [DW-1:0] expw;
    int idx;
    int cyc;
    bit rdy;
    model_load(m, sd);
    mode = m; seed = sd; n = CW'(nn); start = 1'b1;
    tick();
    start = hold_start;
    if (hold_start) begin
      mode = 3'd4; seed = $urandom; n = CW'(0);
    end
    idx = 0; cyc = 0;
    model_word(expw);
    while (idx < nn && cyc < 60 * nn + 60) begin
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || out_data !== expw) begin
        bad++;
        $display("FAIL run_word m=%0d idx=%0d: got valid=%b busy=%b done=%b data=%h, want 1 1 0 %h",
                 m, idx, out_valid, busy, done, out_data, expw);
      end
      if (idx == 0) first_word = out_data;
      rdy = ($urandom_range(99) < rpct);
      out_ready = rdy;
      if (rdy && idx == nn - 1) start = 1'b0;
      tick();
      cyc++;
      if (rdy) begin
        idx++;
        if (idx < nn) model_word(expw);
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    total++;
    if (idx != nn) begin
      bad++;
      $display("FAIL run_timeout: got %0d words, want %0d", idx, nn);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL run_done: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; mode = 3'd0; seed = 31'h7F; n = CW'(3); out_ready = 1'b1;
    tick(); tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b done=%b cfg_err=%b, want all 0",
               out_valid, out_data, busy, done, cfg_err);
    end
    RST = 1'b0; start = 1'b0; out_ready = 1'b0;
    tick();
    run_counted(3'd4, 31'h7FFF_FFFF, 1, 100, 1'b0);
    cold_word = first_word;
    tick();
  endtask

  task automatic test_prbs7_known();
    logic [DW-1:0] w;
    mode = 3'd0; seed = 31'h7F; n = CW'(3); out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h40) begin
      bad++;
      $display("FAIL prbs7_w0: got valid=%b data=%h, want 1 40", out_valid, out_data);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h30) begin
      bad++;
      $display("FAIL prbs7_w1: got valid=%b data=%h, want 1 30", out_valid, out_data);
    end
    tick();
    model_load(3'd0, 31'h7F);
    model_word(w); model_word(w); model_word(w);
    total++;
    if (out_valid !== 1'b1 || out_data !== w || done !== 1'b0) begin
      bad++;
      $display("FAIL prbs7_w2: got valid=%b data=%h done=%b, want 1 %h 0", out_valid, out_data, done, w);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL prbs7_done: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, out_valid);
    end
    out_ready = 1'b0;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL prbs7_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_seed_zero();
    run_counted(3'd0, 31'h0, 2, 100, 1'b0);
    total++;
    if (first_word !== 8'h40) begin
      bad++;
      $display("FAIL seed_zero_w0: got %h, want 40", first_word);
    end
    run_counted(3'd3, 31'h7F80_0000, 3, 70, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    mode = 3'd0; seed = 31'h7F; n = CW'(2); out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h40) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d: got valid=%b data=%h, want 1 40", k, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h30) begin
      bad++;
      $display("FAIL bp_w1: got valid=%b data=%h, want 1 30", out_valid, out_data);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_done: got done=%b busy=%b, want 1 0", done, busy);
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    logic [DW-1:0] e;
    int werr;
    int perr;
    int k;
    werr = 0; perr = 0;
    mode = 3'd2; seed = 31'h7FFF; n = CW'(0); out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    model_load(3'd2, 31'h7FFF);
    for (int w = 0; w < 16384; w++) begin
      model_word(e);
      if (out_valid !== 1'b1 || out_data !== e) werr++;
      for (int i = 0; i < DW; i++) begin
        k = w * DW + i;
        if (k < PER15) per_bits[k] = out_data[i];
        else if (per_bits[k % PER15] !== out_data[i]) perr++;
      end
      tick();
    end
    total++;
    if (werr != 0) begin
      bad++;
      $display("FAIL cont_words: got %0d mismatching words, want 0", werr);
    end
    total++;
    if (perr != 0) begin
      bad++;
      $display("FAIL cont_period: got %0d bits off the 32767-bit period, want 0", perr);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL cont_busy: got %b, want 1", busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop: got busy=%b valid=%b done=%b, want 0 0 0", busy, out_valid, done);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop_after: got done=%b busy=%b, want 0 0", done, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reserved_and_busy_start();
    for (int m = 5; m < 8; m++) begin
      mode = 3'(m); seed = $urandom; n = CW'(2); start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reserved_m%0d: got cfg_err=%b busy=%b valid=%b, want 1 0 0", m, cfg_err, busy, out_valid);
      end
      tick();
      total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reserved_pulse_m%0d: got cfg_err=%b busy=%b, want 0 0", m, cfg_err, busy);
      end
    end
    run_counted(3'd1, $urandom, 3, 60, 1'b1);
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_after: got busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      run_counted(3'($urandom_range(4)), $urandom, $urandom_range(1, 5), 60, 1'b0);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    mode = 3'd4; seed = $urandom; n = CW'(0); start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got valid=%b data=%h busy=%b done=%b cfg_err=%b, want all 0",
               out_valid, out_data, busy, done, cfg_err);
    end
    run_counted(3'd4, 31'h7FFF_FFFF, 2, 100, 1'b0);
    total++;
    if (first_word !== cold_word) begin
      bad++;
      $display("FAIL midrun_first_word: got %h, want %h", first_word, cold_word);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_prbs7_known();
    test_seed_zero();
    test_backpressure();
    test_reserved_and_busy_start();
    test_back_to_back();
    test_continuous();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
